x_par8_rx: RTL and testbench
============================

// Module: x_par8_rx
// PURPOSE
//  Serial receiver and parity checker for 8-bit frames; the far end of the 8-input XOR parity generator.
//  Frame: 1 start (0), 8 data (LSB first), 1 parity, 1 stop (1).
//  Oversamples line RXD, samples each bit at mid-point, deserializes, recomputes XOR parity.
//  Presents byte with parity/framing flags. Sits between an external serial pin and the byte-consumer logic.
// PARAMETERS
//  CLKS_PER_BIT  16  CLK cycles per serial bit; must be even and >= 4
//  ODD_PARITY    0   0: even parity (XOR of 8 data + parity == 0); 1: odd (== 1)
// PORTS
//  CLK      input   1  single clock; all state on rising edge
//  RST_N    input   1  asynchronous, active-low reset
//  RXD      input   1  serial line, asynchronous to CLK, idle high
//  DATA     output  8  received byte, held until next VALID
//  VALID    output  1  one-cycle pulse: DATA/PAR_ERR/FRM_ERR updated
//  PAR_ERR  output  1  parity mismatch on frame flagged by VALID; held with DATA
//  FRM_ERR  output  1  stop bit sampled 0 on frame flagged by VALID; held with DATA
//  BUSY     output  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset (RST_N=0, async): state IDLE, DATA=8'h00, VALID=0, PAR_ERR=0, FRM_ERR=0, BUSY=0,
//   synchronizer flops=1, counters=0. Reset mid-frame discards the frame; no VALID.
//  RXD passes a 2-flop synchronizer (reset value 1); all decisions use synced RXD_S.
//  Counters: cyc_cnt counts 0..CLKS_PER_BIT-1; bit_cnt counts 0..7.
//  FSM states:
//   IDLE:    RXD_S==0 -> START, cyc_cnt=0.
//   START:   at cyc_cnt==CLKS_PER_BIT/2-1 re-sample; RXD_S==1 -> IDLE (glitch, no VALID),
//            else -> DATA, cyc_cnt=0, bit_cnt=0.
//   DATA:    at cyc_cnt==CLKS_PER_BIT-1 shift RXD_S into shreg[7] (right shift, LSB first);
//            bit_cnt==7 -> PARITY, else bit_cnt++.
//   PARITY:  at cyc_cnt==CLKS_PER_BIT-1 capture parity bit p -> STOP.
//   STOP:    at cyc_cnt==CLKS_PER_BIT-1: DATA<=shreg; PAR_ERR<=(^shreg ^ p) != ODD_PARITY;
//            FRM_ERR<=~RXD_S; VALID pulses next cycle (registered); RXD_S==1 -> IDLE, else -> WAIT_HI.
//   WAIT_HI: stay until RXD_S==1 -> IDLE (break/stuck-low line; no further VALID).
//  VALID asserts for exactly one CLK; frames with errors still deliver DATA with flags set.
//  Latency: VALID rises 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + CLKS_PER_BIT + 1 cycles
//   after the RXD falling edge of the start bit (+/-1 for sync phase).
//  Back-to-back frames: new start bit accepted in the cycle after returning to IDLE;
//   since the stop sample is mid-bit, the next start edge is never missed.
//  cyc_cnt wraps to 0 on every bit-boundary sample; no other wrap conditions.
//  DATA/flags change only on a STOP sample; never on glitch or reset-abort.
// STRUCTURE
//  Package x_par8_pkg: state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HI), FRAME_DATA_BITS=8,
//   parity-mode constants PAR_EVEN/PAR_ODD.
//  Sub-module x_sync2: 2-flop synchronizer, async active-low reset to 1; instantiated once for RXD.
//  Parity via reduction XOR of shreg; no separate instance needed.
// TESTING (CLKS_PER_BIT=16, ODD_PARITY=0 unless stated)
//  1. Send 0xA5, p=0, stop=1 -> one VALID, DATA=8'hA5, PAR_ERR=0, FRM_ERR=0, BUSY back to 0.
//  2. Send 0x07, p=0 (wrong) -> VALID, DATA=8'h07, PAR_ERR=1; ODD_PARITY=1 with p=0 -> PAR_ERR=0.
//  3. RXD low for 4 cycles then high -> returns to IDLE, no VALID, DATA unchanged.
//  4. Send 0x3C, p=0, stop=0, line low 40 cycles -> VALID with FRM_ERR=1, FSM in WAIT_HI,
//     next frame 0x81 (p=0) after line high -> DATA=8'h81, FRM_ERR=0.
//  5. Two frames back-to-back (0x55 then 0xFF, zero idle) -> two VALIDs 176 cycles apart (+/-1), both correct.
//  6. RST_N low during DATA bit 4 -> all outputs 0 immediately; release, send 0x12 -> DATA=8'h12, no stale VALID.

Source files
------------

// File: rtl/x_par8_pkg.sv
// x_par8_pkg: shared types and constants for the 8-bit serial parity receiver
package x_par8_pkg;
    localparam int FRAME_DATA_BITS = 8;
    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} rx_state_t;
endpackage

// File: rtl/x_sync2.sv
// x_sync2: two-flop synchronizer, resets to 1 so an idle-high line reads idle
//  clk   in  1  clock
//  rst_n in  1  async active-low reset
//  d     in  1  asynchronous input
//  q     out 1  synchronized output
module x_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic ff1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= 1'b1;
            q   <= 1'b1;
        end else begin
            ff1 <= d;
            q   <= ff1;
        end
    end
endmodule

// File: rtl/x_par8_rx.sv
// x_par8_rx: serial receiver for start + 8 data (LSB first) + parity + stop frames with parity/framing check
//  clk     in  1  clock, all state on rising edge
//  rst_n   in  1  async active-low reset
//  rxd     in  1  serial line, idle high, asynchronous to clk
//  data    out 8  received byte, held until next valid
//  valid   out 1  one-cycle pulse when data/par_err/frm_err update
//  par_err out 1  parity mismatch for the delivered byte
//  frm_err out 1  stop bit sampled low for the delivered byte
//  busy    out 1  receiver not idle
module x_par8_rx
    import x_par8_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit ODD_PARITY   = PAR_EVEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rxd,
    output logic [FRAME_DATA_BITS-1:0] data,
    output logic                       valid,
    output logic                       par_err,
    output logic                       frm_err,
    output logic                       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    rx_state_t state, state_nxt;
    logic [CW-1:0] cyc_cnt, cyc_nxt;
    logic [2:0] bit_cnt, bit_nxt;
    logic [FRAME_DATA_BITS-1:0] shreg, shreg_nxt;
    logic p, p_nxt, cap, rxd_s, bit_end;
    x_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(rxd), .q(rxd_s));
    assign bit_end = cyc_cnt == LAST;
    assign busy    = state != IDLE;
    // Samples land mid-bit because START only waits half a bit before handing to DATA
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        p_nxt     = p;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                cyc_nxt = '0;
                if (!rxd_s) state_nxt = START;
            end
            START: if (cyc_cnt == HALF) begin
                cyc_nxt   = '0;
                bit_nxt   = '0;
                state_nxt = rxd_s ? IDLE : DATA;
            end
            DATA: if (bit_end) begin
                cyc_nxt   = '0;
                shreg_nxt = {rxd_s, shreg[FRAME_DATA_BITS-1:1]};
                bit_nxt   = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_nxt = PARITY;
            end
            PARITY: if (bit_end) begin
                cyc_nxt   = '0;
                p_nxt     = rxd_s;
                state_nxt = STOP;
            end
            STOP: if (bit_end) begin
                cyc_nxt   = '0;
                cap       = 1'b1;
                state_nxt = rxd_s ? IDLE : WAIT_HI;
            end
            WAIT_HI: begin
                cyc_nxt = '0;
                if (rxd_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            p       <= 1'b0;
            data    <= '0;
            valid   <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= shreg_nxt;
            p       <= p_nxt;
            valid   <= cap;
            data    <= cap ? shreg : data;
            par_err <= cap ? ((^shreg ^ p) != ODD_PARITY) : par_err;
            frm_err <= cap ? ~rxd_s : frm_err;
        end
    end
endmodule

// File: tb/tb_x_par8_rx.sv
// tb_x_par8_rx: directed frames into even- and odd-parity receivers sharing one line
module tb_x_par8_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic [7:0] data, data_o;
    logic valid, par_err, frm_err, busy;
    logic valid_o, par_err_o, frm_err_o, busy_o;
    int pass = 0, total = 0, n_valid = 0, cyc = 0;
    int vcyc[$];
    logic [7:0] vdata[$];

    x_par8_rx #(.CLKS_PER_BIT(16), .ODD_PARITY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .data(data), .valid(valid),
        .par_err(par_err), .frm_err(frm_err), .busy(busy));
    x_par8_rx #(.CLKS_PER_BIT(16), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .data(data_o), .valid(valid_o),
        .par_err(par_err_o), .frm_err(frm_err_o), .busy(busy_o));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (valid) begin
        n_valid++;
        vcyc.push_back(cyc);
        vdata.push_back(data);
    end

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        logic [10:0] f;
        f = {stp, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rxd = f[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({data, valid, par_err, frm_err, busy} !== 12'h000) $display("FAIL reset_outputs got=%h want=000", {data, valid, par_err, frm_err, busy}); else pass++;
        rst_n = 1'b1;
        idle(5);
        total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b want=0", busy); else pass++;
    endtask

    task automatic test_good_frame;
        int v0;
        v0 = n_valid;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(4);
        total++; if (n_valid !== v0 + 1) $display("FAIL a5_valid_count got=%0d want=%0d", n_valid - v0, 1); else pass++;
        total++; if (data !== 8'hA5) $display("FAIL a5_data got=%h want=a5", data); else pass++;
        total++; if ({par_err, frm_err} !== 2'b00) $display("FAIL a5_flags got=%b want=00", {par_err, frm_err}); else pass++;
        total++; if (busy !== 1'b0) $display("FAIL a5_busy got=%b want=0", busy); else pass++;
        total++; if (par_err_o !== 1'b1) $display("FAIL a5_odd_par_err got=%b want=1", par_err_o); else pass++;
    endtask

    task automatic test_parity;
        int v0;
        v0 = n_valid;
        send_frame(8'h07, 1'b0, 1'b1);
        idle(4);
        total++; if (n_valid !== v0 + 1) $display("FAIL par_valid_count got=%0d want=1", n_valid - v0); else pass++;
        total++; if (data !== 8'h07) $display("FAIL par_data got=%h want=07", data); else pass++;
        total++; if (par_err !== 1'b1) $display("FAIL par_even_err got=%b want=1", par_err); else pass++;
        total++; if (par_err_o !== 1'b0) $display("FAIL par_odd_err got=%b want=0", par_err_o); else pass++;
        total++; if (data_o !== 8'h07) $display("FAIL par_odd_data got=%h want=07", data_o); else pass++;
    endtask

    task automatic test_glitch;
        int v0;
        v0 = n_valid;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        idle(30);
        total++; if (n_valid !== v0) $display("FAIL glitch_valid got=%0d want=0", n_valid - v0); else pass++;
        total++; if (data !== 8'h07) $display("FAIL glitch_data got=%h want=07", data); else pass++;
        total++; if (busy !== 1'b0) $display("FAIL glitch_busy got=%b want=0", busy); else pass++;
    endtask

    task automatic test_framing;
        int v0;
        v0 = n_valid;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        total++; if (n_valid !== v0 + 1) $display("FAIL frm_valid_count got=%0d want=1", n_valid - v0); else pass++;
        total++; if (frm_err !== 1'b1) $display("FAIL frm_err got=%b want=1", frm_err); else pass++;
        total++; if (data !== 8'h3C) $display("FAIL frm_data got=%h want=3c", data); else pass++;
        total++; if (busy !== 1'b1) $display("FAIL frm_wait_hi_busy got=%b want=1", busy); else pass++;
        idle(20);
        total++; if (busy !== 1'b0) $display("FAIL frm_release_busy got=%b want=0", busy); else pass++;
        send_frame(8'h81, 1'b0, 1'b1);
        idle(4);
        total++; if (n_valid !== v0 + 2) $display("FAIL frm_next_valid got=%0d want=2", n_valid - v0); else pass++;
        total++; if ({data, par_err, frm_err} !== {8'h81, 2'b00}) $display("FAIL frm_next_frame got=%h want=%h", {data, par_err, frm_err}, {8'h81, 2'b00}); else pass++;
    endtask

    task automatic test_back_to_back;
        int v0, gap;
        v0 = n_valid;
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(4);
        total++; if (n_valid !== v0 + 2) $display("FAIL b2b_valid_count got=%0d want=2", n_valid - v0); else pass++;
        if (n_valid == v0 + 2) begin
            gap = vcyc[v0 + 1] - vcyc[v0];
            total++; if (gap < 175 || gap > 177) $display("FAIL b2b_gap got=%0d want=176", gap); else pass++;
            total++; if (vdata[v0] !== 8'h55) $display("FAIL b2b_first got=%h want=55", vdata[v0]); else pass++;
            total++; if (vdata[v0 + 1] !== 8'hFF) $display("FAIL b2b_second got=%h want=ff", vdata[v0 + 1]); else pass++;
        end
        total++; if ({par_err, frm_err} !== 2'b00) $display("FAIL b2b_flags got=%b want=00", {par_err, frm_err}); else pass++;
    endtask

    task automatic test_reset_abort;
        int v0;
        logic [7:0] d;
        d = 8'hC3;
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            repeat (16) @(negedge clk);
        end
        rxd = d[4];
        repeat (8) @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL abort_busy_before got=%b want=1", busy); else pass++;
        rst_n = 1'b0;
        #1;
        total++; if ({data, valid, par_err, frm_err, busy} !== 12'h000) $display("FAIL abort_outputs got=%h want=000", {data, valid, par_err, frm_err, busy}); else pass++;
        v0 = n_valid;
        idle(3);
        rst_n = 1'b1;
        idle(200);
        total++; if (n_valid !== v0) $display("FAIL abort_stale_valid got=%0d want=0", n_valid - v0); else pass++;
        send_frame(8'h12, 1'b0, 1'b1);
        idle(4);
        total++; if (n_valid !== v0 + 1) $display("FAIL abort_next_valid got=%0d want=1", n_valid - v0); else pass++;
        total++; if ({data, par_err, frm_err} !== {8'h12, 2'b00}) $display("FAIL abort_next_frame got=%h want=%h", {data, par_err, frm_err}, {8'h12, 2'b00}); else pass++;
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_parity;
        test_glitch;
        test_framing;
        test_back_to_back;
        test_reset_abort;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
